// File: rtl/hack_pkg.sv
// Shared types for the Hack CPU fetch path: address/instruction words and the
// {instr, pc} entry carried by the output and skid registers.
package hack_pkg;
  localparam int HACK_ADDR_W  = 15;
  localparam int HACK_INSTR_W = 16;

  typedef logic [HACK_ADDR_W-1:0]  hack_addr_t;
  typedef logic [HACK_INSTR_W-1:0] hack_instr_t;

  typedef struct packed {
    hack_instr_t instr;
    hack_addr_t  pc;
  } fetch_entry_t;
endpackage

// File: rtl/hack_fetch_skid.sv
// Output register backed by a 1-entry skid slot. A word arriving while the
// output is held parks in the skid and refills the output on the next accept.
module hack_fetch_skid
  import hack_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  input  fetch_entry_t in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output fetch_entry_t out_data,
  output logic         skid_valid
);
  fetch_entry_t skid_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // skid and in_valid are never both set: issue is blocked while skid is full
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
endmodule

// File: rtl/hack_fetch.sv
// Hack CPU instruction fetch: PC, ROM request issue, jump redirect and
// handshake to decode. Define HACK_FETCH_PERF_EN for perf_fetched/perf_stall.
module hack_fetch
  import hack_pkg::*;
#(
  parameter int                ADDR_W   = HACK_ADDR_W,
  parameter int                INSTR_W  = HACK_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
`ifdef HACK_FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);
  logic [ADDR_W-1:0] pc_q, inflight_pc;
  logic              inflight_valid, skid_valid, issue;
  fetch_entry_t      ret, out;

  // Also hold off when the returning word is about to take the skid slot,
  // otherwise the next return could find both registers full.
  assign issue = !skid_valid && !(inflight_valid && instr_valid && !instr_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q           <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
    end else if (jump_valid) begin
      pc_q           <= jump_target;
      inflight_valid <= 1'b0;
    end else begin
      inflight_valid <= issue;
      if (issue) begin
        inflight_pc <= pc_q;
        pc_q        <= pc_q + 1'b1;
      end
    end
  end

  assign rom_addr  = pc_q;
  assign ret.instr = rom_data;
  assign ret.pc    = inflight_pc;

  hack_fetch_skid u_skid (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (jump_valid),
    .in_valid   (inflight_valid),
    .in_data    (ret),
    .out_ready  (instr_ready),
    .out_valid  (instr_valid),
    .out_data   (out),
    .skid_valid (skid_valid)
  );

  assign instr    = out.instr;
  assign instr_pc = out.pc;

`ifdef HACK_FETCH_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (instr_valid && instr_ready)  perf_fetched <= perf_fetched + 32'd1;
      if (instr_valid && !instr_ready) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hack_fetch.sv
// Directed bench for hack_fetch with a 1-cycle ROM model (word = addr ^ 0xA5A5).
module tb_hack_fetch;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [14:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic        jump_valid;
  logic [14:0] jump_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [14:0] instr_pc;
`ifdef HACK_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  int vectors = 0, errors = 0;
  int n_fetch = 0, n_stall = 0;
  int bad_instr = 0, hold_bad = 0;
  int seq[$];
  logic        hs;
  logic [14:0] hs_pc;
  logic [15:0] hs_instr;

  hack_fetch dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
`ifdef HACK_FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) rom_data <= {1'b0, rom_addr} ^ 16'hA5A5;

  function automatic logic [15:0] rom_word(input logic [14:0] a);
    return {1'b0, a} ^ 16'hA5A5;
  endfunction

  task automatic tick();
    hs       = instr_valid && instr_ready;
    hs_pc    = instr_pc;
    hs_instr = instr;
    if (instr_valid && instr_ready)  n_fetch++;
    if (instr_valid && !instr_ready) n_stall++;
    @(posedge clock);
    #1;
  endtask

  // Gathers delivered pcs into seq; records instr and hold violations.
  task automatic collect(input int n, input int budget, input bit rnd);
    logic pv;
    logic [14:0] ppc;
    logic [15:0] pin;
    seq.delete();
    for (int c = 0; c < budget && seq.size() < n; c++) begin
      if (rnd) instr_ready = 1'($urandom_range(0, 1));
      pv = instr_valid && !instr_ready;
      ppc = instr_pc;
      pin = instr;
      tick();
      if (pv && (!instr_valid || instr_pc != ppc || instr != pin)) hold_bad++;
      if (hs) begin
        seq.push_back(int'(hs_pc));
        if (hs_instr != rom_word(hs_pc)) bad_instr++;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; instr_ready = 1'b1; jump_valid = 1'b0; jump_target = '0;
    @(posedge clock); @(posedge clock); #1;
    vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
    vectors++; if (instr !== 16'h0) begin errors++; $display("FAIL reset_instr got %h want 0000", instr); end
    vectors++; if (instr_pc !== 15'h0) begin errors++; $display("FAIL reset_pc got %h want 0000", instr_pc); end
    vectors++; if (rom_addr !== 15'h0) begin errors++; $display("FAIL reset_rom_addr got %h want 0000", rom_addr); end
    reset_n = 1'b1;
    tick();
    vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL first_cycle_valid got %0b want 0", instr_valid); end
    tick();
    vectors++; if (!(instr_valid === 1'b1 && instr_pc === 15'h0 && instr === rom_word(15'h0)))
      begin errors++; $display("FAIL first_valid got v=%0b pc=%h i=%h want v=1 pc=0000 i=%h", instr_valid, instr_pc, instr, rom_word(15'h0)); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++; if (!(instr_valid === 1'b1 && instr_pc === 15'(i) && instr === rom_word(15'(i))))
        begin errors++; $display("FAIL stream got v=%0b pc=%h i=%h want pc=%h", instr_valid, instr_pc, instr, 15'(i)); end
    end
  endtask

  task automatic test_stall();
    tick();
    vectors++; if (instr_pc !== 15'd4) begin errors++; $display("FAIL stall_start_pc got %h want 0004", instr_pc); end
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (!(instr_valid === 1'b1 && instr_pc === 15'd4 && instr === rom_word(15'd4)))
        begin errors++; $display("FAIL stall_hold got v=%0b pc=%h i=%h want pc=0004", instr_valid, instr_pc, instr); end
    end
    vectors++; if (rom_addr !== 15'd6) begin errors++; $display("FAIL stall_pc_q got %h want 0006", rom_addr); end
    instr_ready = 1'b1;
    collect(4, 12, 1'b0);
    vectors++; if (seq.size() != 4) begin errors++; $display("FAIL stall_count got %0d want 4", seq.size()); end
    for (int i = 0; i < seq.size(); i++) begin
      vectors++; if (seq[i] != 4 + i) begin errors++; $display("FAIL stall_order got %h want %h", seq[i], 4 + i); end
    end
  endtask

  task automatic test_jump();
    jump_valid = 1'b1; jump_target = 15'h0010; instr_ready = 1'b0;
    tick();
    jump_valid = 1'b0;
    tick(); tick(); tick();
    vectors++; if (!(instr_valid === 1'b1 && instr_pc === 15'h0010 && rom_addr === 15'h0012))
      begin errors++; $display("FAIL jump_setup got v=%0b pc=%h addr=%h want v=1 pc=0010 addr=0012", instr_valid, instr_pc, rom_addr); end
    jump_valid = 1'b1; jump_target = 15'h002E;
    tick();
    vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL jump_flush got %0b want 0", instr_valid); end
    jump_valid = 1'b0; instr_ready = 1'b1;
    for (int k = 0; k < 2 && !instr_valid; k++) tick();
    vectors++; if (!(instr_valid === 1'b1 && instr_pc === 15'h002E))
      begin errors++; $display("FAIL jump_latency got v=%0b pc=%h want v=1 pc=002e", instr_valid, instr_pc); end
    collect(3, 10, 1'b0);
    vectors++; if (seq.size() != 3) begin errors++; $display("FAIL jump_count got %0d want 3", seq.size()); end
    for (int i = 0; i < seq.size(); i++) begin
      vectors++; if (seq[i] != 'h2E + i) begin errors++; $display("FAIL jump_order got %h want %h", seq[i], 'h2E + i); end
    end
  endtask

  task automatic test_wrap();
    int exp_pc[4] = '{'h7FFE, 'h7FFF, 'h0000, 'h0001};
    instr_ready = 1'b1; jump_valid = 1'b1; jump_target = 15'h7FFE;
    tick();
    jump_valid = 1'b0;
    collect(4, 10, 1'b0);
    vectors++; if (seq.size() != 4) begin errors++; $display("FAIL wrap_count got %0d want 4", seq.size()); end
    for (int i = 0; i < seq.size(); i++) begin
      vectors++; if (seq[i] != exp_pc[i]) begin errors++; $display("FAIL wrap_order got %h want %h", seq[i], exp_pc[i]); end
    end
  endtask

  task automatic test_back_to_back();
    instr_ready = 1'b1;
    jump_valid = 1'b1; jump_target = 15'h0100;
    tick();
    jump_target = 15'h0200;
    tick();
    jump_valid = 1'b0;
    vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_flush got %0b want 0", instr_valid); end
    collect(10, 80, 1'b1);
    vectors++; if (seq.size() != 10) begin errors++; $display("FAIL b2b_count got %0d want 10", seq.size()); end
    for (int i = 0; i < seq.size(); i++) begin
      vectors++; if (seq[i] != 'h200 + i) begin errors++; $display("FAIL b2b_order got %h want %h", seq[i], 'h200 + i); end
    end
    vectors++; if (hold_bad != 0) begin errors++; $display("FAIL held_output got %0d violations want 0", hold_bad); end
    vectors++; if (bad_instr != 0) begin errors++; $display("FAIL instr_data got %0d bad words want 0", bad_instr); end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0;
    tick(); tick(); tick();
    #2 reset_n = 1'b0;
    n_fetch = 0; n_stall = 0;
    #1;
    vectors++; if (!(instr_valid === 1'b0 && instr === 16'h0 && instr_pc === 15'h0 && rom_addr === 15'h0))
      begin errors++; $display("FAIL async_reset got v=%0b i=%h pc=%h addr=%h want all 0", instr_valid, instr, instr_pc, rom_addr); end
    @(posedge clock); #1;
    reset_n = 1'b1; instr_ready = 1'b1;
    collect(3, 10, 1'b0);
    vectors++; if (seq.size() != 3) begin errors++; $display("FAIL restart_count got %0d want 3", seq.size()); end
    for (int i = 0; i < seq.size(); i++) begin
      vectors++; if (seq[i] != i) begin errors++; $display("FAIL restart_order got %h want %h", seq[i], i); end
    end
    instr_ready = 1'b0;
    tick(); tick();
    instr_ready = 1'b1;
    tick();
`ifdef HACK_FETCH_PERF_EN
    vectors++; if (perf_fetched !== 32'(n_fetch)) begin errors++; $display("FAIL perf_fetched got %0d want %0d", perf_fetched, n_fetch); end
    vectors++; if (perf_stall !== 32'(n_stall)) begin errors++; $display("FAIL perf_stall got %0d want %0d", perf_stall, n_stall); end
`endif
  endtask

  initial begin
    test_reset();
    test_stall();
    test_jump();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
